mac_learning_cam: RTL and testbench
===================================

Name: mac_learning_cam

Overview:
- Switch MAC table that sits directly downstream of the output-port-lookup register block.
- Serves that block's rd_req/rd_ack and wr_req/wr_ack table-access handshakes, and produces its lut_hit/lut_miss count pulses.
- Serves per-packet lookups from the header parser: destination-MAC match gives an output-queue mask; source-MAC learning is automatic.
- Table is a register array of 2**LUT_DEPTH_BITS entries, each {valid, wr_protect, oq, mac}, with fully parallel compare.

Parameters:
NUM_OUTPUT_QUEUES, 5, width of one-hot/mask output-queue fields (max 15)
LUT_DEPTH_BITS, 4, log2 of table entries

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
lookup_req  in  1  lookup request; accepted when lookup_req && lookup_rdy
lookup_rdy  out  1  block can accept a lookup this cycle
lookup_dst_mac  in  48  destination MAC (bit 40 = I/G bit)
lookup_src_mac  in  48  source MAC
lookup_src_oq  in  NUM_OUTPUT_QUEUES  one-hot queue of ingress port
lookup_done  out  1  one-cycle result strobe
lookup_hit  out  1  destination matched a valid entry
lookup_dst_oq  out  NUM_OUTPUT_QUEUES  forwarding mask
lut_hit  out  1  one-cycle hit count pulse
lut_miss  out  1  one-cycle miss count pulse
rd_addr  in  LUT_DEPTH_BITS  table entry to read
rd_req  in  1  level read request
rd_oq  out  NUM_OUTPUT_QUEUES  entry oq
rd_wr_protect  out  1  entry protect bit
rd_mac  out  48  entry MAC
rd_ack  out  1  high while rd_req held after data valid
wr_addr  in  LUT_DEPTH_BITS  table entry to write
wr_req  in  1  level write request
wr_oq  in  NUM_OUTPUT_QUEUES  oq to write
wr_protect  in  1  protect bit to write
wr_mac  in  48  MAC to write
wr_ack  out  1  high while wr_req held after write done

Behaviour:
- Reset: all outputs 0; all entries cleared (valid=0, fields 0); replacement pointer 0; state IDLE. Reset mid-operation aborts any lookup or register access; no done/ack is issued.
- States: IDLE, COMPARE, RESOLVE, REG_WR, REG_RD.
- lookup_rdy = (state==IDLE) && !rd_req && !wr_req. Register access has priority over lookups.
- IDLE, wr_req=1: at that edge, entry[wr_addr] <= {valid=(wr_oq!=0), wr_protect, wr_oq, wr_mac}; go to REG_WR.
- REG_WR: wr_ack=1; when wr_req=0, wr_ack=0 and return to IDLE.
- IDLE, rd_req=1 (wr_req=0): at that edge, register entry[rd_addr] fields onto rd_*; go to REG_RD.
- REG_RD: rd_ack=1; rd_* held stable; when rd_req=0, rd_ack=0 and return to IDLE.
- Lookup accept at edge N: latch dst MAC, src MAC and src_oq; go to COMPARE.
- COMPARE: at edge N+1, register per-entry valid&&mac==dst and valid&&mac==src match vectors, plus lowest matching index of each; go to RESOLVE.
- RESOLVE: at edge N+2, lookup_done/lut_hit/lut_miss and results are registered, valid for exactly one cycle. Learning write happens at the same edge. Return to IDLE; lookup_rdy can be 1 the cycle after lookup_done.
- Destination result:
  - Group dst (bit 40=1), or no match: lookup_hit=0, lookup_dst_oq = all-ones & ~src_oq, lut_miss=1.
  - Match: lookup_hit=1, lookup_dst_oq = entry.oq & ~src_oq, lut_hit=1.
  - Exactly one of lut_hit/lut_miss pulses per lookup.
- Learning uses only match results from COMPARE. The destination result reflects the table before this packet's learn write.
  - Group src, or src_oq==0: no learn.
  - Src match, entry unprotected, oq differs: entry.oq <= src_oq.
  - Src match, entry protected: no change.
  - Src miss: if entry[ptr] is unprotected, entry[ptr] <= {1,0,src_oq,src_mac}; else skip. ptr increments modulo depth in both cases.
- Multiple matching entries: lowest index wins.
- Registers written via wr_req bypass the pointer; the pointer is unchanged.

Test Plan:
- Reset, then read entry 3 -> rd_ack=1 one cycle after rd_req, rd_mac=0, rd_oq=0, rd_wr_protect=0; rd_ack drops the cycle after rd_req drops.
- Write entry 2 {mac=0x001122334455, oq=5'b00100, protect=1}, then lookup dst=0x001122334455, src_oq=5'b00001 -> lookup_done 2 clocks after accept, lookup_hit=1, lookup_dst_oq=5'b00100, lut_hit=1.
- Lookup dst=0xFFFFFFFFFFFF, src=0x0000000000AA, src_oq=5'b00010 on empty table -> lookup_dst_oq=5'b11101, lut_miss=1; entry 0 learned {valid,0,5'b00010,0xAA}; pointer=1.
- Same src 0xAA re-seen with src_oq=5'b01000 -> entry 0 oq=5'b01000. Src 0x001122334455 seen with src_oq=5'b00001 -> protected entry 2 unchanged.
- Hold rd_req high while lookup_req pulses -> lookup_rdy=0 until the REG_RD access completes; lookup then completes normally.
- Assert reset during COMPARE -> no lookup_done; table read back all zero.

Source files
------------

// File: rtl/mac_learning_cam_if.sv
// ============================================================================
// Module      : mac_learning_cam_if
// Description : Lookup and register-access bundle for the MAC learning table.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mac_learning_cam_if #(
    parameter int NUM_OUTPUT_QUEUES = 5,
    parameter int LUT_DEPTH_BITS    = 4
);
    logic                         lookup_req;
    logic                         lookup_rdy;
    logic [47:0]                  lookup_dst_mac;
    logic [47:0]                  lookup_src_mac;
    logic [NUM_OUTPUT_QUEUES-1:0] lookup_src_oq;
    logic                         lookup_done;
    logic                         lookup_hit;
    logic [NUM_OUTPUT_QUEUES-1:0] lookup_dst_oq;
    logic                         lut_hit;
    logic                         lut_miss;

    logic [LUT_DEPTH_BITS-1:0]    rd_addr;
    logic                         rd_req;
    logic [NUM_OUTPUT_QUEUES-1:0] rd_oq;
    logic                         rd_wr_protect;
    logic [47:0]                  rd_mac;
    logic                         rd_ack;

    logic [LUT_DEPTH_BITS-1:0]    wr_addr;
    logic                         wr_req;
    logic [NUM_OUTPUT_QUEUES-1:0] wr_oq;
    logic                         wr_protect;
    logic [47:0]                  wr_mac;
    logic                         wr_ack;

    modport master (
        output lookup_req, lookup_dst_mac, lookup_src_mac, lookup_src_oq,
        input  lookup_rdy, lookup_done, lookup_hit, lookup_dst_oq, lut_hit, lut_miss,
        output rd_addr, rd_req,
        input  rd_oq, rd_wr_protect, rd_mac, rd_ack,
        output wr_addr, wr_req, wr_oq, wr_protect, wr_mac,
        input  wr_ack
    );

    modport slave (
        input  lookup_req, lookup_dst_mac, lookup_src_mac, lookup_src_oq,
        output lookup_rdy, lookup_done, lookup_hit, lookup_dst_oq, lut_hit, lut_miss,
        input  rd_addr, rd_req,
        output rd_oq, rd_wr_protect, rd_mac, rd_ack,
        input  wr_addr, wr_req, wr_oq, wr_protect, wr_mac,
        output wr_ack
    );
endinterface

`default_nettype wire

// File: rtl/mac_learning_cam.sv
// ============================================================================
// Module      : mac_learning_cam
// Description : Switch MAC table with parallel compare, source learning and
//               register read/write access.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mac_learning_cam #(
    parameter int NUM_OUTPUT_QUEUES = 5,
    parameter int LUT_DEPTH_BITS    = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    mac_learning_cam_if.slave   bus
);
    localparam int c_depth = 1 << LUT_DEPTH_BITS;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPARE = 3'd1,
        ST_RESOLVE = 3'd2,
        ST_REG_WR  = 3'd3,
        ST_REG_RD  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [c_depth-1:0]                         valid_q, valid_d;
    logic [c_depth-1:0]                         prot_q, prot_d;
    logic [c_depth-1:0][NUM_OUTPUT_QUEUES-1:0]  oq_q, oq_d;
    logic [c_depth-1:0][47:0]                   mac_q, mac_d;
    logic [LUT_DEPTH_BITS-1:0]                  ptr_q, ptr_d;

    logic [47:0]                  dst_mac_q, dst_mac_d;
    logic [47:0]                  src_mac_q, src_mac_d;
    logic [NUM_OUTPUT_QUEUES-1:0] src_oq_q, src_oq_d;
    logic                         dst_hit_q, dst_hit_d;
    logic                         src_hit_q, src_hit_d;
    logic [LUT_DEPTH_BITS-1:0]    dst_idx_q, dst_idx_d;
    logic [LUT_DEPTH_BITS-1:0]    src_idx_q, src_idx_d;

    logic                         lookup_done_q, lookup_done_d;
    logic                         lookup_hit_q, lookup_hit_d;
    logic [NUM_OUTPUT_QUEUES-1:0] lookup_dst_oq_q, lookup_dst_oq_d;
    logic                         lut_hit_q, lut_hit_d;
    logic                         lut_miss_q, lut_miss_d;
    logic [NUM_OUTPUT_QUEUES-1:0] rd_oq_q, rd_oq_d;
    logic                         rd_wr_protect_q, rd_wr_protect_d;
    logic [47:0]                  rd_mac_q, rd_mac_d;
    logic                         rd_ack_q, rd_ack_d;
    logic                         wr_ack_q, wr_ack_d;

    logic                         w_dst_hit, w_src_hit;
    logic [LUT_DEPTH_BITS-1:0]    w_dst_idx, w_src_idx;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_dst_hit = 1'b0;
        w_src_hit = 1'b0;
        w_dst_idx = '0;
        w_src_idx = '0;
        for (int i = c_depth - 1; i >= 0; i--) begin
            if (valid_q[i] && (mac_q[i] == dst_mac_q)) begin
                w_dst_hit = 1'b1;
                w_dst_idx = LUT_DEPTH_BITS'(i);
            end
            if (valid_q[i] && (mac_q[i] == src_mac_q)) begin
                w_src_hit = 1'b1;
                w_src_idx = LUT_DEPTH_BITS'(i);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        prot_d          = prot_q;
        oq_d            = oq_q;
        mac_d           = mac_q;
        ptr_d           = ptr_q;
        dst_mac_d       = dst_mac_q;
        src_mac_d       = src_mac_q;
        src_oq_d        = src_oq_q;
        dst_hit_d       = dst_hit_q;
        src_hit_d       = src_hit_q;
        dst_idx_d       = dst_idx_q;
        src_idx_d       = src_idx_q;
        lookup_done_d   = 1'b0;
        lookup_hit_d    = 1'b0;
        lookup_dst_oq_d = '0;
        lut_hit_d       = 1'b0;
        lut_miss_d      = 1'b0;
        rd_oq_d         = rd_oq_q;
        rd_wr_protect_d = rd_wr_protect_q;
        rd_mac_d        = rd_mac_q;
        rd_ack_d        = rd_ack_q;
        wr_ack_d        = wr_ack_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.wr_req) begin
                    valid_d[bus.wr_addr] = (bus.wr_oq != '0);
                    prot_d[bus.wr_addr]  = bus.wr_protect;
                    oq_d[bus.wr_addr]    = bus.wr_oq;
                    mac_d[bus.wr_addr]   = bus.wr_mac;
                    wr_ack_d             = 1'b1;
                    state_d              = ST_REG_WR;
                end else if (bus.rd_req) begin
                    rd_oq_d         = oq_q[bus.rd_addr];
                    rd_wr_protect_d = prot_q[bus.rd_addr];
                    rd_mac_d        = mac_q[bus.rd_addr];
                    rd_ack_d        = 1'b1;
                    state_d         = ST_REG_RD;
                end else if (bus.lookup_req) begin
                    dst_mac_d = bus.lookup_dst_mac;
                    src_mac_d = bus.lookup_src_mac;
                    src_oq_d  = bus.lookup_src_oq;
                    state_d   = ST_COMPARE;
                end
            end
            ST_REG_WR: begin
                if (!bus.wr_req) begin
                    wr_ack_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_REG_RD: begin
                if (!bus.rd_req) begin
                    rd_ack_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                dst_hit_d = w_dst_hit;
                src_hit_d = w_src_hit;
                dst_idx_d = w_dst_idx;
                src_idx_d = w_src_idx;
                state_d   = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                lookup_done_d = 1'b1;
                // Group destinations flood even if the address sits in the table.
                if (dst_mac_q[40] || !dst_hit_q) begin
                    lookup_dst_oq_d = ~src_oq_q;
                    lut_miss_d      = 1'b1;
                end else begin
                    lookup_hit_d    = 1'b1;
                    lookup_dst_oq_d = oq_q[dst_idx_q] & ~src_oq_q;
                    lut_hit_d       = 1'b1;
                end
                if (!src_mac_q[40] && (src_oq_q != '0)) begin
                    if (src_hit_q) begin
                        if (!prot_q[src_idx_q]) begin
                            oq_d[src_idx_q] = src_oq_q;
                        end
                    end else begin
                        // Protected slots are skipped, but the pointer still advances.
                        if (!prot_q[ptr_q]) begin
                            valid_d[ptr_q] = 1'b1;
                            prot_d[ptr_q]  = 1'b0;
                            oq_d[ptr_q]    = src_oq_q;
                            mac_d[ptr_q]   = src_mac_q;
                        end
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            valid_q         <= '0;
            prot_q          <= '0;
            oq_q            <= '0;
            mac_q           <= '0;
            ptr_q           <= '0;
            dst_mac_q       <= '0;
            src_mac_q       <= '0;
            src_oq_q        <= '0;
            dst_hit_q       <= 1'b0;
            src_hit_q       <= 1'b0;
            dst_idx_q       <= '0;
            src_idx_q       <= '0;
            lookup_done_q   <= 1'b0;
            lookup_hit_q    <= 1'b0;
            lookup_dst_oq_q <= '0;
            lut_hit_q       <= 1'b0;
            lut_miss_q      <= 1'b0;
            rd_oq_q         <= '0;
            rd_wr_protect_q <= 1'b0;
            rd_mac_q        <= '0;
            rd_ack_q        <= 1'b0;
            wr_ack_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            prot_q          <= prot_d;
            oq_q            <= oq_d;
            mac_q           <= mac_d;
            ptr_q           <= ptr_d;
            dst_mac_q       <= dst_mac_d;
            src_mac_q       <= src_mac_d;
            src_oq_q        <= src_oq_d;
            dst_hit_q       <= dst_hit_d;
            src_hit_q       <= src_hit_d;
            dst_idx_q       <= dst_idx_d;
            src_idx_q       <= src_idx_d;
            lookup_done_q   <= lookup_done_d;
            lookup_hit_q    <= lookup_hit_d;
            lookup_dst_oq_q <= lookup_dst_oq_d;
            lut_hit_q       <= lut_hit_d;
            lut_miss_q      <= lut_miss_d;
            rd_oq_q         <= rd_oq_d;
            rd_wr_protect_q <= rd_wr_protect_d;
            rd_mac_q        <= rd_mac_d;
            rd_ack_q        <= rd_ack_d;
            wr_ack_q        <= wr_ack_d;
        end
    end

    assign bus.lookup_rdy    = (state_q == ST_IDLE) && !bus.rd_req && !bus.wr_req;
    assign bus.lookup_done   = lookup_done_q;
    assign bus.lookup_hit    = lookup_hit_q;
    assign bus.lookup_dst_oq = lookup_dst_oq_q;
    assign bus.lut_hit       = lut_hit_q;
    assign bus.lut_miss      = lut_miss_q;
    assign bus.rd_oq         = rd_oq_q;
    assign bus.rd_wr_protect = rd_wr_protect_q;
    assign bus.rd_mac        = rd_mac_q;
    assign bus.rd_ack        = rd_ack_q;
    assign bus.wr_ack        = wr_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_learning_cam.sv
// ============================================================================
// Module      : tb_mac_learning_cam
// Description : Randomised bench for mac_learning_cam with a table-level model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mac_learning_cam;
    localparam int NQ    = 5;
    localparam int DB    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_learning_cam_if #(.NUM_OUTPUT_QUEUES(NQ), .LUT_DEPTH_BITS(DB)) bus ();
    mac_learning_cam #(.NUM_OUTPUT_QUEUES(NQ), .LUT_DEPTH_BITS(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Table-level model: the table as plain arrays plus "busy" bookkeeping.
    logic            m_valid [DEPTH];
    logic            m_prot  [DEPTH];
    logic [NQ-1:0]   m_oq    [DEPTH];
    logic [47:0]     m_mac   [DEPTH];
    int              m_ptr;
    int              m_lk_cnt;
    bit              m_rd, m_wr;
    logic            p_hit;
    logic [NQ-1:0]   p_oq;
    logic            e_done, e_hit, e_lut_hit, e_lut_miss, e_rd_ack, e_wr_ack, e_rd_prot;
    logic [NQ-1:0]   e_dst_oq, e_rd_oq;
    logic [47:0]     e_rd_mac;

    function automatic int find_mac(input logic [47:0] mac);
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && m_mac[i] == mac) return i;
        return -1;
    endfunction

    task automatic model_lookup(input logic [47:0] dst, input logic [47:0] src, input logic [NQ-1:0] soq);
        int d;
        int s;
        d     = dst[40] ? -1 : find_mac(dst);
        p_hit = (d >= 0);
        p_oq  = ((d >= 0) ? m_oq[d] : {NQ{1'b1}}) & ~soq;
        if (!src[40] && soq != '0) begin
            s = find_mac(src);
            if (s >= 0) begin
                if (!m_prot[s]) m_oq[s] = soq;
            end else begin
                if (!m_prot[m_ptr]) begin
                    m_valid[m_ptr] = 1'b1;
                    m_prot[m_ptr]  = 1'b0;
                    m_oq[m_ptr]    = soq;
                    m_mac[m_ptr]   = src;
                end
                m_ptr = (m_ptr + 1) % DEPTH;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_valid[i] = 1'b0; m_prot[i] = 1'b0; m_oq[i] = '0; m_mac[i] = '0;
                end
                m_ptr = 0; m_lk_cnt = 0; m_rd = 1'b0; m_wr = 1'b0;
                e_done = 0; e_hit = 0; e_lut_hit = 0; e_lut_miss = 0; e_dst_oq = '0;
                e_rd_ack = 0; e_wr_ack = 0; e_rd_oq = '0; e_rd_prot = 0; e_rd_mac = '0;
            end else begin
                e_done = 0; e_lut_hit = 0; e_lut_miss = 0;
                if (m_lk_cnt > 0) begin
                    m_lk_cnt--;
                    if (m_lk_cnt == 0) begin
                        e_done = 1; e_hit = p_hit; e_dst_oq = p_oq;
                        e_lut_hit = p_hit; e_lut_miss = !p_hit;
                    end
                end else if (m_wr) begin
                    if (!bus.wr_req) begin m_wr = 1'b0; e_wr_ack = 1'b0; end
                end else if (m_rd) begin
                    if (!bus.rd_req) begin m_rd = 1'b0; e_rd_ack = 1'b0; end
                end else if (bus.wr_req) begin
                    m_valid[bus.wr_addr] = (bus.wr_oq != '0);
                    m_prot[bus.wr_addr]  = bus.wr_protect;
                    m_oq[bus.wr_addr]    = bus.wr_oq;
                    m_mac[bus.wr_addr]   = bus.wr_mac;
                    m_wr = 1'b1; e_wr_ack = 1'b1;
                end else if (bus.rd_req) begin
                    e_rd_oq   = m_oq[bus.rd_addr];
                    e_rd_prot = m_prot[bus.rd_addr];
                    e_rd_mac  = m_mac[bus.rd_addr];
                    m_rd = 1'b1; e_rd_ack = 1'b1;
                end else if (bus.lookup_req) begin
                    model_lookup(bus.lookup_dst_mac, bus.lookup_src_mac, bus.lookup_src_oq);
                    m_lk_cnt = 2;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("lookup_rdy", bus.lookup_rdy,
                      (m_lk_cnt == 0 && !m_rd && !m_wr && !bus.rd_req && !bus.wr_req));
                check("lookup_done", bus.lookup_done, e_done);
                check("lut_hit", bus.lut_hit, e_lut_hit);
                check("lut_miss", bus.lut_miss, e_lut_miss);
                if (e_done) begin
                    check("lookup_hit", bus.lookup_hit, e_hit);
                    check("lookup_dst_oq", bus.lookup_dst_oq, e_dst_oq);
                end
                check("rd_ack", bus.rd_ack, e_rd_ack);
                check("wr_ack", bus.wr_ack, e_wr_ack);
                check("rd_mac", bus.rd_mac, e_rd_mac);
                check("rd_oq", bus.rd_oq, e_rd_oq);
                check("rd_wr_protect", bus.rd_wr_protect, e_rd_prot);
            end
        end
    end

    task automatic do_write(input logic [DB-1:0] a, input logic [47:0] mac,
                            input logic [NQ-1:0] oq, input logic prot);
        int n;
        @(posedge clk); #1;
        bus.wr_addr = a; bus.wr_mac = mac; bus.wr_oq = oq; bus.wr_protect = prot; bus.wr_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.wr_ack && n < 10);
        if (!bus.wr_ack) check("wr_ack_timeout", 0, 1);
        @(posedge clk); #1 bus.wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [DB-1:0] a, output logic [47:0] mac,
                           output logic [NQ-1:0] oq, output logic prot, output int lat);
        @(posedge clk); #1;
        bus.rd_addr = a; bus.rd_req = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            if (bus.rd_ack || lat >= 10) break;
            lat++;
        end
        if (!bus.rd_ack) check("rd_ack_timeout", 0, 1);
        mac = bus.rd_mac; oq = bus.rd_oq; prot = bus.rd_wr_protect;
        @(posedge clk); #1 bus.rd_req = 1'b0;
    endtask

    task automatic do_lookup(input logic [47:0] dst, input logic [47:0] src, input logic [NQ-1:0] soq,
                             output logic hit, output logic [NQ-1:0] doq,
                             output logic lh, output logic lm, output int lat);
        int n;
        @(posedge clk); #1;
        bus.lookup_dst_mac = dst; bus.lookup_src_mac = src; bus.lookup_src_oq = soq; bus.lookup_req = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.lookup_rdy || n >= 20) break;
            n++;
        end
        if (!bus.lookup_rdy) check("lookup_accept_timeout", 0, 1);
        @(posedge clk); #1 bus.lookup_req = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (bus.lookup_done || lat >= 10) break;
            lat++;
        end
        if (!bus.lookup_done) check("lookup_done_timeout", 0, 1);
        hit = bus.lookup_hit; doq = bus.lookup_dst_oq; lh = bus.lut_hit; lm = bus.lut_miss;
    endtask

    logic [47:0] pool [8];
    logic [47:0] r_mac;
    logic [NQ-1:0] r_oq;
    logic r_prot, r_hit, r_lh, r_lm;
    int r_lat;

    function automatic logic [47:0] pick_mac();
        logic [47:0] m;
        if ($urandom_range(0, 3) == 0) begin
            m = {16'($urandom), 32'($urandom)};
            m[40] = 1'b0;
        end else begin
            m = pool[$urandom_range(0, 7)];
        end
        return m;
    endfunction

    initial begin
        pool = '{48'h001122334455, 48'h0000000000AA, 48'h0000000000CC, 48'h02AB00000001,
                 48'h02AB00000002, 48'hFFFFFFFFFFFF, 48'h010000000005, 48'h0A0B0C0D0E0F};
        bus.lookup_req = 0; bus.lookup_dst_mac = '0; bus.lookup_src_mac = '0; bus.lookup_src_oq = '0;
        bus.rd_req = 0; bus.rd_addr = '0;
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_mac = '0; bus.wr_oq = '0; bus.wr_protect = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset_lookup_done", bus.lookup_done, 0);
        check("reset_rd_ack", bus.rd_ack, 0);
        check("reset_lookup_rdy", bus.lookup_rdy, 1);

        do_read(4'd3, r_mac, r_oq, r_prot, r_lat);
        check("rd3_latency", r_lat, 1);
        check("rd3_mac", r_mac, 0);
        check("rd3_oq", r_oq, 0);
        check("rd3_prot", r_prot, 0);

        do_lookup(48'hFFFFFFFFFFFF, 48'h0000000000AA, 5'b00010, r_hit, r_oq, r_lh, r_lm, r_lat);
        check("bcast_latency", r_lat, 2);
        check("bcast_hit", r_hit, 0);
        check("bcast_oq", r_oq, 5'b11101);
        check("bcast_lut_miss", r_lm, 1);
        do_read(4'd0, r_mac, r_oq, r_prot, r_lat);
        check("learn0_mac", r_mac, 48'h0000000000AA);
        check("learn0_oq", r_oq, 5'b00010);
        check("learn0_prot", r_prot, 0);

        do_write(4'd2, 48'h001122334455, 5'b00100, 1'b1);
        do_lookup(48'h001122334455, 48'h001122334455, 5'b00001, r_hit, r_oq, r_lh, r_lm, r_lat);
        check("uc_latency", r_lat, 2);
        check("uc_hit", r_hit, 1);
        check("uc_oq", r_oq, 5'b00100);
        check("uc_lut_hit", r_lh, 1);
        do_read(4'd2, r_mac, r_oq, r_prot, r_lat);
        check("prot2_oq", r_oq, 5'b00100);
        check("prot2_prot", r_prot, 1);

        do_lookup(48'h0000000000AA, 48'h0000000000AA, 5'b01000, r_hit, r_oq, r_lh, r_lm, r_lat);
        check("move_hit", r_hit, 1);
        check("move_oq", r_oq, 5'b00010);
        do_read(4'd0, r_mac, r_oq, r_prot, r_lat);
        check("moved0_oq", r_oq, 5'b01000);

        do_lookup(48'h0000000000DD, 48'h0000000000CC, 5'b00001, r_hit, r_oq, r_lh, r_lm, r_lat);
        check("miss_oq", r_oq, 5'b11110);
        do_read(4'd1, r_mac, r_oq, r_prot, r_lat);
        check("learn1_mac", r_mac, 48'h0000000000CC);
        check("learn1_oq", r_oq, 5'b00001);

        // Register read held open while a lookup is waiting.
        @(posedge clk); #1;
        bus.rd_addr = 4'd0; bus.rd_req = 1'b1;
        bus.lookup_dst_mac = 48'h0000000000CC; bus.lookup_src_mac = 48'h0000000000AA;
        bus.lookup_src_oq = 5'b01000; bus.lookup_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("hold_rdy_low", bus.lookup_rdy, 0);
        end
        check("hold_rd_ack", bus.rd_ack, 1);
        @(posedge clk); #1 bus.rd_req = 1'b0;
        do_lookup(48'h0000000000CC, 48'h0000000000AA, 5'b01000, r_hit, r_oq, r_lh, r_lm, r_lat);
        check("after_hold_hit", r_hit, 1);
        check("after_hold_oq", r_oq, 5'b00001);

        for (int it = 0; it < 300; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 2) begin
                do_write(DB'($urandom_range(0, DEPTH - 1)), pick_mac(),
                         ($urandom_range(0, 5) == 0) ? '0 : NQ'($urandom_range(1, 31)),
                         ($urandom_range(0, 7) == 0));
            end else if (op < 4) begin
                do_read(DB'($urandom_range(0, DEPTH - 1)), r_mac, r_oq, r_prot, r_lat);
            end else begin
                do_lookup(pick_mac(), pick_mac(),
                          ($urandom_range(0, 7) == 0) ? '0 : NQ'(1 << $urandom_range(0, NQ - 1)),
                          r_hit, r_oq, r_lh, r_lm, r_lat);
            end
        end

        // Reset while a lookup sits in the compare stage.
        @(posedge clk); #1;
        bus.lookup_dst_mac = 48'h0000000000AA; bus.lookup_src_mac = 48'h02AB00000009;
        bus.lookup_src_oq = 5'b00100; bus.lookup_req = 1'b1;
        @(posedge clk); #1;
        bus.lookup_req = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_done", bus.lookup_done, 0);
        end
        for (int a = 0; a < DEPTH; a++) begin
            do_read(DB'(a), r_mac, r_oq, r_prot, r_lat);
            check("cleared_mac", r_mac, 0);
            check("cleared_oq", r_oq, 0);
            check("cleared_prot", r_prot, 0);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
